relu_maxpool2x2_stream: RTL and testbench

- Streaming ReLU plus 2x2/stride-2 max-pool stage. Sits directly downstream of one conv2d_3 featuremap filter.
- Consumes that filter's biased FP32 pixel stream (data_out/valid_out), one pixel per valid cycle, in raster order.
- Emits one pooled FP32 pixel per 2x2 window to the next layer's input FIFO.
- One instance per filter; no backpressure, matching the upstream stream.

---
 rtl/relu_maxpool2x2_stream_if.sv | 32 +++
 rtl/relu_maxpool2x2_stream.sv | 107 ++++++++++
 tb/tb_relu_maxpool2x2_stream.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/relu_maxpool2x2_stream_if.sv
// Pixel stream bundle for the ReLU + 2x2 max-pool stage.
// Stream semantics: valid-only, with no ready. data_in is consumed on every
// rising clk edge where valid_in=1. valid_out is a one-cycle pulse qualifying
// data_out. frame_done pulses together with the last pooled pixel of a frame.
// The sink must accept every pulse.
interface relu_maxpool2x2_stream_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  valid_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  frame_done;

   // Upstream side: the filter output driving pixels in.
   modport master (
      output valid_in,
      output data_in,
      input  valid_out,
      input  data_out,
      input  frame_done
   );

   // Pooling stage side.
   modport slave (
      input  valid_in,
      input  data_in,
      output valid_out,
      output data_out,
      output frame_done
   );
endinterface

// File: rtl/relu_maxpool2x2_stream.sv
// Streaming ReLU followed by a 2x2 / stride-2 max-pool over a raster-order
// FP32 pixel stream. Even columns park the pixel in a hold register. Odd
// columns form the horizontal pair max. In even rows that pair max goes to a
// half-width line buffer. In odd rows it is combined with the stored pair
// max from the row above and emitted.
// After ReLU the sign bit is always 0, so an unsigned compare of bits
// [30:0] orders the values correctly. Positive Inf and NaN sort highest.
module relu_maxpool2x2_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = 56,
   parameter int HEIGHT     = 56
) (
   input logic                     clk,
   input logic                     rst,
   relu_maxpool2x2_stream_if.slave pix
);
   localparam int CW   = $clog2(WIDTH);
   localparam int RW   = $clog2(HEIGHT);
   localparam int HALF = WIDTH / 2;
   localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic [DATA_WIDTH-1:0] hold;
   logic [DATA_WIDTH-1:0] linebuf [HALF];

   logic                  valid_out_q;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  frame_done_q;

   logic [DATA_WIDTH-1:0] relu_px;
   logic [DATA_WIDTH-1:0] h_max;
   logic [DATA_WIDTH-1:0] lb_rd;
   logic [DATA_WIDTH-1:0] pool_max;
   logic [LW-1:0]         lb_idx;
   logic                  col_last;
   logic                  row_last;

   assign lb_idx   = LW'(col >> 1);
   assign col_last = (col == CW'(WIDTH - 1));
   assign row_last = (row == RW'(HEIGHT - 1));

   // ReLU: any pixel with the sign bit set (negatives, -0, negative NaN) becomes +0.
   always_comb begin
      relu_px = pix.data_in;
      if (pix.data_in[DATA_WIDTH-1]) begin
         relu_px = '0;
      end
   end

   // Horizontal pair max and the final 2x2 max against the line buffer entry.
   always_comb begin
      h_max    = relu_px;
      lb_rd    = linebuf[lb_idx];
      pool_max = h_max;
      if (hold[DATA_WIDTH-2:0] >= relu_px[DATA_WIDTH-2:0]) begin
         h_max = hold;
      end
      pool_max = h_max;
      if (lb_rd[DATA_WIDTH-2:0] >= h_max[DATA_WIDTH-2:0]) begin
         pool_max = lb_rd;
      end
   end

   // Line buffer stores the even-row pair maxima. It is not reset, because every
   // entry is written in an even row before the next odd row reads it.
   always_ff @(posedge clk) begin
      if (rst && pix.valid_in && col[0] && !row[0]) begin
         linebuf[lb_idx] <= h_max;
      end
   end

   // Raster position counters, hold register and output pulses.
   // Reset wins over a coincident valid pixel.
   always_ff @(posedge clk) begin
      if (!rst) begin
         col          <= '0;
         row          <= '0;
         hold         <= '0;
         valid_out_q  <= 1'b0;
         data_out_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         valid_out_q  <= 1'b0;
         frame_done_q <= 1'b0;
         if (pix.valid_in) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            if (!col[0]) begin
               hold <= relu_px;
            end else if (row[0]) begin
               data_out_q   <= pool_max;
               valid_out_q  <= 1'b1;
               frame_done_q <= col_last && row_last;
            end
         end
      end
   end

   assign pix.valid_out  = valid_out_q;
   assign pix.data_out   = data_out_q;
   assign pix.frame_done = frame_done_q;
endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
// Bench for relu_maxpool2x2_stream: a 4x4 instance for the directed and gap
// scenarios, and a default 56x56 instance for a random full frame.
module tb_relu_maxpool2x2_stream;
   typedef logic [31:0] word_q_t[$];

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   relu_maxpool2x2_stream_if #(.DATA_WIDTH(32)) bs ();
   relu_maxpool2x2_stream_if #(.DATA_WIDTH(32)) bb ();

   relu_maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) dut_s (
      .clk(clk), .rst(rst), .pix(bs)
   );
   relu_maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(56), .HEIGHT(56)) dut_b (
      .clk(clk), .rst(rst), .pix(bb)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- scoreboard storage ----------------
   logic [31:0] exp_q[$];
   bit          exp_fd_q[$];
   int          edge_q[$];

   logic [31:0] obs_s_q[$];
   bit          obs_s_fd[$];
   int          obs_s_cyc[$];
   int          stray_s = 0;
   logic [31:0] obs_b_q[$];
   bit          obs_b_fd[$];
   int          stray_b = 0;

   // Output monitors sample on the falling edge.
   always @(negedge clk) begin
      if (bs.valid_out === 1'b1) begin
         obs_s_q.push_back(bs.data_out);
         obs_s_fd.push_back(bs.frame_done);
         obs_s_cyc.push_back(cyc);
      end else if (bs.frame_done === 1'b1) begin
         stray_s++;
      end
      if (bb.valid_out === 1'b1) begin
         obs_b_q.push_back(bb.data_out);
         obs_b_fd.push_back(bb.frame_done);
      end else if (bb.frame_done === 1'b1) begin
         stray_b++;
      end
   end

   task automatic clear_obs();
      obs_s_q.delete(); obs_s_fd.delete(); obs_s_cyc.delete(); stray_s = 0;
      obs_b_q.delete(); obs_b_fd.delete(); stray_b = 0;
      exp_q.delete(); exp_fd_q.delete(); edge_q.delete();
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] relu(input logic [31:0] x);
      return x[31] ? 32'h0 : x;
   endfunction

   // Appends the pooled outputs of one w x h frame in raster window order.
   task automatic model_frame(input word_q_t frame, input int w, input int h);
      for (int wr = 0; wr < h / 2; wr++) begin
         for (int wc = 0; wc < w / 2; wc++) begin
            logic [31:0] m;
            m = 32'h0;
            for (int dy = 0; dy < 2; dy++) begin
               for (int dx = 0; dx < 2; dx++) begin
                  logic [31:0] v;
                  v = relu(frame[(2 * wr + dy) * w + 2 * wc + dx]);
                  if (v > m) m = v;
               end
            end
            exp_q.push_back(m);
            exp_fd_q.push_back((wr == h / 2 - 1) && (wc == w / 2 - 1));
         end
      end
   endtask

   // ---------------- drivers ----------------
   // Sets inputs just after a rising edge; records the edge that samples them.
   task automatic drive(input bit big, input logic v, input logic [31:0] d);
      @(posedge clk);
      #1;
      if (big) begin
         bb.valid_in = v; bb.data_in = d;
      end else begin
         bs.valid_in = v; bs.data_in = d;
      end
      if (v) edge_q.push_back(cyc + 1);
   endtask

   task automatic send_frame(input bit big, input word_q_t frame, input bit gaps);
      foreach (frame[i]) begin
         if (gaps) begin
            while ($urandom_range(0, 1) == 1) drive(big, 1'b0, $urandom);
         end
         drive(big, 1'b1, frame[i]);
      end
      drive(big, 1'b0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      bs.valid_in = 1'b0; bs.data_in = 32'h0;
      bb.valid_in = 1'b0; bb.data_in = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bs.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_s got=%b want=0", bs.valid_out); end
      checks++; if (bs.data_out !== 32'h0) begin errors++; $display("FAIL reset_data_s got=%h want=0", bs.data_out); end
      checks++; if (bs.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd_s got=%b want=0", bs.frame_done); end
      checks++; if (bb.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_b got=%b want=0", bb.valid_out); end
      checks++; if (bb.data_out !== 32'h0) begin errors++; $display("FAIL reset_data_b got=%h want=0", bb.data_out); end
      rst = 1'b1;
   endtask

   task automatic test_ramp();
      word_q_t frame;
      logic [31:0] want [4];
      int idx [4];
      frame = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
      want = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
      idx  = '{5, 7, 13, 15};
      clear_obs();
      send_frame(1'b0, frame, 1'b0);
      checks++; if (obs_s_q.size() !== 4) begin errors++; $display("FAIL ramp_count got=%0d want=4", obs_s_q.size()); end
      for (int i = 0; i < 4 && i < obs_s_q.size(); i++) begin
         checks++; if (obs_s_q[i] !== want[i]) begin errors++; $display("FAIL ramp_value[%0d] got=%h want=%h", i, obs_s_q[i], want[i]); end
         checks++; if (obs_s_cyc[i] !== edge_q[idx[i]]) begin errors++; $display("FAIL ramp_latency[%0d] got=%0d want=%0d", i, obs_s_cyc[i], edge_q[idx[i]]); end
         checks++; if (obs_s_fd[i] !== (i == 3)) begin errors++; $display("FAIL ramp_frame_done[%0d] got=%b want=%b", i, obs_s_fd[i], (i == 3)); end
      end
      checks++; if (stray_s !== 0) begin errors++; $display("FAIL ramp_stray_fd got=%0d want=0", stray_s); end
   endtask

   task automatic test_negative();
      word_q_t frame;
      for (int i = 0; i < 16; i++) frame.push_back((i == 3) ? 32'h80000000 : 32'hC0200000);
      clear_obs();
      send_frame(1'b0, frame, 1'b0);
      checks++; if (obs_s_q.size() !== 4) begin errors++; $display("FAIL neg_count got=%0d want=4", obs_s_q.size()); end
      for (int i = 0; i < obs_s_q.size(); i++) begin
         checks++; if (obs_s_q[i] !== 32'h0) begin errors++; $display("FAIL neg_value[%0d] got=%h want=00000000", i, obs_s_q[i]); end
      end
   endtask

   task automatic test_mixed();
      word_q_t frame;
      logic [31:0] top [2];
      logic [31:0] bot [2];
      top = '{32'hBF800000, 32'h3F000000};
      bot = '{32'hC0400000, 32'h3E800000};
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            frame.push_back((r % 2 == 0) ? top[c % 2] : bot[c % 2]);
      clear_obs();
      send_frame(1'b0, frame, 1'b0);
      checks++; if (obs_s_q.size() !== 4) begin errors++; $display("FAIL mixed_count got=%0d want=4", obs_s_q.size()); end
      for (int i = 0; i < obs_s_q.size(); i++) begin
         checks++; if (obs_s_q[i] !== 32'h3F000000) begin errors++; $display("FAIL mixed_value[%0d] got=%h want=3f000000", i, obs_s_q[i]); end
      end
   endtask

   task automatic test_back_to_back_gaps();
      word_q_t f1, f2, both;
      int fd_cnt;
      for (int i = 0; i < 16; i++) f1.push_back($urandom);
      for (int i = 0; i < 16; i++) f2.push_back($urandom);
      both = {f1, f2};
      clear_obs();
      model_frame(f1, 4, 4);
      model_frame(f2, 4, 4);
      send_frame(1'b0, both, 1'b1);
      checks++; if (obs_s_q.size() !== 8) begin errors++; $display("FAIL gaps_count got=%0d want=8", obs_s_q.size()); end
      fd_cnt = 0;
      for (int i = 0; i < obs_s_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_s_q[i] !== exp_q[i]) begin errors++; $display("FAIL gaps_value[%0d] got=%h want=%h", i, obs_s_q[i], exp_q[i]); end
         checks++; if (obs_s_fd[i] !== exp_fd_q[i]) begin errors++; $display("FAIL gaps_frame_done[%0d] got=%b want=%b", i, obs_s_fd[i], exp_fd_q[i]); end
         if (obs_s_fd[i]) fd_cnt++;
      end
      fd_cnt += stray_s;
      checks++; if (fd_cnt !== 2) begin errors++; $display("FAIL gaps_fd_total got=%0d want=2", fd_cnt); end
   endtask

   task automatic test_reset_mid_frame();
      word_q_t part, frame;
      for (int i = 0; i < 6; i++) part.push_back({1'b0, 31'($urandom)});
      for (int i = 0; i < 16; i++) frame.push_back($urandom);
      clear_obs();
      model_frame({part, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 4, 4);
      send_frame(1'b0, part, 1'b0);
      // The (1,1) pixel of the partial frame completes a window before the abort.
      checks++; if (obs_s_q.size() !== 1) begin errors++; $display("FAIL abort_pre_count got=%0d want=1", obs_s_q.size()); end
      if (obs_s_q.size() > 0) begin
         checks++; if (obs_s_q[0] !== exp_q[0]) begin errors++; $display("FAIL abort_pre_value got=%h want=%h", obs_s_q[0], exp_q[0]); end
      end
      // Reset with a coincident valid pixel: the pixel must be discarded.
      @(posedge clk);
      #1;
      rst = 1'b0; bs.valid_in = 1'b1; bs.data_in = 32'h7F7FFFFF;
      @(posedge clk);
      #1;
      rst = 1'b1; bs.valid_in = 1'b0;
      checks++; if (bs.valid_out !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b want=0", bs.valid_out); end
      checks++; if (bs.data_out !== 32'h0) begin errors++; $display("FAIL abort_data got=%h want=0", bs.data_out); end
      clear_obs();
      model_frame(frame, 4, 4);
      send_frame(1'b0, frame, 1'b0);
      checks++; if (obs_s_q.size() !== 4) begin errors++; $display("FAIL abort_post_count got=%0d want=4", obs_s_q.size()); end
      for (int i = 0; i < obs_s_q.size() && i < exp_q.size(); i++) begin
         checks++; if (obs_s_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_post_value[%0d] got=%h want=%h", i, obs_s_q[i], exp_q[i]); end
         checks++; if (obs_s_fd[i] !== exp_fd_q[i]) begin errors++; $display("FAIL abort_post_fd[%0d] got=%b want=%b", i, obs_s_fd[i], exp_fd_q[i]); end
      end
   endtask

   task automatic test_full_frame_56();
      word_q_t frame;
      int bad, fd_cnt;
      for (int i = 0; i < 56 * 56; i++) frame.push_back($urandom);
      clear_obs();
      model_frame(frame, 56, 56);
      send_frame(1'b1, frame, 1'b0);
      checks++; if (obs_b_q.size() !== 784) begin errors++; $display("FAIL big_count got=%0d want=784", obs_b_q.size()); end
      bad = 0;
      fd_cnt = stray_b;
      for (int i = 0; i < obs_b_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (obs_b_q[i] !== exp_q[i]) begin
            errors++;
            if (bad < 10) $display("FAIL big_value[%0d] got=%h want=%h", i, obs_b_q[i], exp_q[i]);
            bad++;
         end
         if (obs_b_fd[i]) fd_cnt++;
      end
      checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL big_fd_total got=%0d want=1", fd_cnt); end
      if (obs_b_fd.size() > 0) begin
         checks++; if (obs_b_fd[obs_b_fd.size() - 1] !== 1'b1) begin errors++; $display("FAIL big_fd_last got=0 want=1"); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_ramp();
      test_negative();
      test_mixed();
      test_back_to_back_gaps();
      test_reset_mid_frame();
      test_full_frame_56();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
